// File: rtl/result_uart_tx.sv
// Converts a solver result to decimal ASCII with a serial double-dabble and
// sends it once per reset as 8N1 UART frames ("<digits>\r\n" or "ERR\r\n").
module result_uart_tx #(
  parameter int ANSWER_W     = 64,
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Done,
  input  logic                Error,
  input  logic [ANSWER_W-1:0] Answer,
  output logic                Tx,
  output logic                Busy,
  output logic                Sent
);

  localparam int NDIG   = (ANSWER_W * 30103) / 100000 + 1;
  localparam int BCD_W  = 4 * NDIG;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int CONV_W = $clog2(ANSWER_W + 1);
  localparam int IDX_W  = $clog2(NDIG + 3);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CONVERT  = 2'd1,
    S_SEND     = 2'd2,
    S_FINISHED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ANSWER_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic                err_q, err_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                sent_q, sent_d;

  logic [BCD_W-1:0]    adj_s;
  logic [IDX_W-1:0]    msd_s;
  logic [IDX_W-1:0]    di_s;
  logic [3:0]          digit_s;
  logic [7:0]          cur_byte_s;
  logic                last_byte_s;

  function automatic logic [7:0] err_byte(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): return 8'h45;
      IDX_W'(1): return 8'h52;
      IDX_W'(2): return 8'h52;
      IDX_W'(3): return 8'h0D;
      default:   return 8'h0A;
    endcase
  endfunction

  // Add-3 correction and leading-digit search over the BCD register
  always_comb begin
    adj_s = '0;
    msd_s = '0;
    for (int i = 0; i < NDIG; i++) begin
      adj_s[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3) : bcd_q[4*i +: 4];
      msd_s = (bcd_q[4*i +: 4] != 4'd0) ? IDX_W'(i) : msd_s;
    end
  end

  // Byte currently on the wire, selected by position within the report
  always_comb begin
    di_s    = msd_s - byte_idx_q;
    digit_s = 4'(bcd_q >> {di_s, 2'b00});
    if (err_q) begin
      cur_byte_s  = err_byte(byte_idx_q);
      last_byte_s = (byte_idx_q == IDX_W'(4));
    end else begin
      if (byte_idx_q <= msd_s) begin
        cur_byte_s = {4'h3, digit_s};
      end else if (byte_idx_q == msd_s + IDX_W'(1)) begin
        cur_byte_s = 8'h0D;
      end else begin
        cur_byte_s = 8'h0A;
      end
      last_byte_s = (byte_idx_q == msd_s + IDX_W'(2));
    end
  end

  // Next-state and next-output logic; Tx is computed one cycle ahead
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    conv_cnt_d = conv_cnt_q;
    clk_cnt_d  = clk_cnt_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    err_d      = err_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    sent_d     = sent_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if ((Error || Done) && !sent_q) begin
          busy_d     = 1'b1;
          clk_cnt_d  = '0;
          bit_d      = 4'd0;
          byte_idx_d = '0;
          if (Error) begin
            err_d   = 1'b1;
            tx_d    = 1'b0;
            state_d = S_SEND;
          end else begin
            err_d      = 1'b0;
            bin_d      = Answer;
            bcd_d      = '0;
            conv_cnt_d = '0;
            state_d    = S_CONVERT;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CONVERT: begin
        bcd_d = {adj_s[BCD_W-2:0], bin_q[ANSWER_W-1]};
        bin_d = {bin_q[ANSWER_W-2:0], 1'b0};
        if (conv_cnt_q == CONV_W'(ANSWER_W - 1)) begin
          tx_d    = 1'b0;
          state_d = S_SEND;
        end else begin
          conv_cnt_d = conv_cnt_q + CONV_W'(1);
        end
      end
      S_SEND: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          if (bit_q == 4'd9) begin
            if (last_byte_s) begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              sent_d  = 1'b1;
              state_d = S_FINISHED;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
              bit_d      = 4'd0;
              tx_d       = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte_s[bit_q[2:0]];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_FINISHED: begin
        tx_d = 1'b1;
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      conv_cnt_q <= '0;
      clk_cnt_q  <= '0;
      bit_q      <= 4'd0;
      byte_idx_q <= '0;
      err_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      conv_cnt_q <= conv_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      err_q      <= err_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Sent = sent_q;

endmodule
